// File: rtl/line_follower_pwm.sv
// Line follower: synchronised and debounced sensor array, 6-state steering FSM,
// and per-wheel PWM whose duty changes only at the period wrap.
module line_follower_pwm #(
  parameter int N_SENSORS    = 5,
  parameter int PWM_W        = 8,
  parameter int DEBOUNCE     = 4,
  parameter int LOST_TIMEOUT = 255,
  parameter int DUTY_FAST    = 200,
  parameter int DUTY_SLOW    = 60,
  parameter int DUTY_SEARCH  = 100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N_SENSORS-1:0] sensors,
  output logic                 motor_left,
  output logic                 motor_right,
  output logic [2:0]           state,
  output logic                 line_lost
);

  localparam int CENTRE = N_SENSORS / 2;
  localparam int DB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE - 1);
  localparam logic [15:0]      TIMEOUT_LAST = 16'(LOST_TIMEOUT - 1);
  localparam logic [PWM_W-1:0] PWM_MAX      = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FWD    = 3'd1,
    LEFT   = 3'd2,
    RIGHT  = 3'd3,
    SEARCH = 3'd4,
    STOP   = 3'd5
  } stateT;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_ALL,
    CLS_CTR,
    CLS_LFT,
    CLS_RGT
  } lineClassT;

  // Duty parameters outside the counter range are clamped rather than truncated.
  function automatic logic [PWM_W-1:0] satDuty(input int d);
    if (d <= 0) return '0;
    if (d >= (1 << PWM_W) - 1) return PWM_MAX;
    return PWM_W'(d);
  endfunction

  function automatic lineClassT classify(input logic [N_SENSORS-1:0] b);
    int nL;
    int nR;
    nL = 0;
    nR = 0;
    for (int i = 0; i < CENTRE; i++) nL += int'(b[i]);
    for (int i = CENTRE + 1; i < N_SENSORS; i++) nR += int'(b[i]);
    if (&b) return CLS_ALL;
    if (b == '0) return CLS_NONE;
    if (b[CENTRE] || (nL == nR)) return CLS_CTR;
    if (nL > nR) return CLS_LFT;
    return CLS_RGT;
  endfunction

  function automatic stateT steer(input lineClassT c);
    case (c)
      CLS_ALL:  return STOP;
      CLS_NONE: return SEARCH;
      CLS_LFT:  return LEFT;
      CLS_RGT:  return RIGHT;
      default:  return FWD;
    endcase
  endfunction

  localparam logic [PWM_W-1:0] DUTY_FAST_Q   = satDuty(DUTY_FAST);
  localparam logic [PWM_W-1:0] DUTY_SLOW_Q   = satDuty(DUTY_SLOW);
  localparam logic [PWM_W-1:0] DUTY_SEARCH_Q = satDuty(DUTY_SEARCH);

  logic [N_SENSORS-1:0] sensSync_p0;
  logic [N_SENSORS-1:0] sensSync_p1;
  logic [DB_W-1:0]      dbCnt;
  logic [N_SENSORS-1:0] blk;

  stateT       stateQ;
  stateT       stateNext;
  lineClassT   lineCls;
  logic        lineLostQ;
  logic        lostNext;
  logic        lastSideR;
  logic [15:0] searchTimer;

  logic [PWM_W-1:0] pwmCnt;
  logic [PWM_W-1:0] dutyLeftAct;
  logic [PWM_W-1:0] dutyRightAct;
  logic [PWM_W-1:0] dutyLeftTgt;
  logic [PWM_W-1:0] dutyRightTgt;
  logic             halt;
  logic             motorLeftQ;
  logic             motorRightQ;

  // Stage p0/p1: two-flop synchroniser; sensors idle white, so reset to ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sensSync_p0 <= '1;
      sensSync_p1 <= '1;
    end else begin
      sensSync_p0 <= sensors;
      sensSync_p1 <= sensSync_p0;
    end
  end

  // Debounce: a change about to land in p1 restarts the count; blk is active-high black.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbCnt <= '0;
      blk   <= '0;
    end else if (sensSync_p0 != sensSync_p1) begin
      dbCnt <= '0;
    end else if (dbCnt != DB_LAST) begin
      dbCnt <= dbCnt + 1'b1;
    end else begin
      blk <= ~sensSync_p1;
    end
  end

  assign lineCls = classify(blk);

  always_comb begin
    stateNext = stateQ;
    lostNext  = 1'b0;
    if (!enable) begin
      stateNext = IDLE;
    end else begin
      case (stateQ)
        IDLE:            stateNext = FWD;
        FWD, LEFT, RIGHT: stateNext = steer(lineCls);
        SEARCH: begin
          if (lineCls != CLS_NONE) begin
            stateNext = steer(lineCls);
          end else if (searchTimer == TIMEOUT_LAST) begin
            stateNext = STOP;
            lostNext  = 1'b1;
          end
        end
        STOP: begin
          stateNext = STOP;
          lostNext  = lineLostQ;
        end
        default: stateNext = IDLE;
      endcase
    end
    if (stateNext == SEARCH) lostNext = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ      <= IDLE;
      lineLostQ   <= 1'b0;
      lastSideR   <= 1'b0;
      searchTimer <= '0;
    end else begin
      stateQ    <= stateNext;
      lineLostQ <= lostNext;
      if (stateQ == LEFT) lastSideR <= 1'b0;
      else if (stateQ == RIGHT) lastSideR <= 1'b1;
      searchTimer <= (stateQ == SEARCH) ? searchTimer + 16'd1 : 16'd0;
    end
  end

  always_comb begin
    dutyLeftTgt  = '0;
    dutyRightTgt = '0;
    case (stateQ)
      FWD: begin
        dutyLeftTgt  = DUTY_FAST_Q;
        dutyRightTgt = DUTY_FAST_Q;
      end
      LEFT: begin
        dutyLeftTgt  = DUTY_SLOW_Q;
        dutyRightTgt = DUTY_FAST_Q;
      end
      RIGHT: begin
        dutyLeftTgt  = DUTY_FAST_Q;
        dutyRightTgt = DUTY_SLOW_Q;
      end
      SEARCH: begin
        if (lastSideR) dutyLeftTgt = DUTY_SEARCH_Q;
        else dutyRightTgt = DUTY_SEARCH_Q;
      end
      default: ;
    endcase
  end

  assign halt = (stateQ == IDLE) || (stateQ == STOP);

  // Active duties reload only at the wrap to avoid runt pulses; halt bypasses that.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwmCnt       <= '0;
      dutyLeftAct  <= '0;
      dutyRightAct <= '0;
      motorLeftQ   <= 1'b0;
      motorRightQ  <= 1'b0;
    end else begin
      pwmCnt <= pwmCnt + 1'b1;
      if (halt) begin
        dutyLeftAct  <= '0;
        dutyRightAct <= '0;
      end else if (pwmCnt == PWM_MAX) begin
        dutyLeftAct  <= dutyLeftTgt;
        dutyRightAct <= dutyRightTgt;
      end
      motorLeftQ  <= !halt && (pwmCnt < dutyLeftAct);
      motorRightQ <= !halt && (pwmCnt < dutyRightAct);
    end
  end

  assign motor_left  = motorLeftQ;
  assign motor_right = motorRightQ;
  assign state       = stateQ;
  assign line_lost   = lineLostQ;

endmodule

// File: tb/tb_line_follower_pwm.sv
// Directed bench for line_follower_pwm with a small-PWM configuration and
// hand-computed expectations, checked with immediate assertions.
module tb_line_follower_pwm;

  localparam logic [15:0] S_IDLE = 0, S_FWD = 1, S_LEFT = 2, S_RIGHT = 3, S_SEARCH = 4, S_STOP = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [4:0] sensors;
  logic       motor_left;
  logic       motor_right;
  logic [2:0] state;
  logic       line_lost;

  int nAsserts = 0;
  int nFails   = 0;
  int cyc;
  int hl, hr;
  int mDuty, cb;

  line_follower_pwm #(
    .N_SENSORS(5), .PWM_W(4), .DEBOUNCE(2), .LOST_TIMEOUT(20),
    .DUTY_FAST(12), .DUTY_SLOW(4), .DUTY_SEARCH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .sensors(sensors),
    .motor_left(motor_left),
    .motor_right(motor_right),
    .state(state),
    .line_lost(line_lost)
  );

  always #5 clk = ~clk;

  // Independent model of the free-running 4-bit PWM counter phase.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic measure(output int nl, output int nr);
    nl = 0;
    nr = 0;
    repeat (16) begin
      @(negedge clk);
      nl += int'(motor_left);
      nr += int'(motor_right);
    end
  endtask

  task automatic waitPhase(input int p);
    for (int i = 0; i < 16 && (cyc % 16) != p; i++) @(negedge clk);
  endtask

  initial begin
    // 1: reset values, enable into FWD, FAST duty on both wheels
    reset = 1'b1; enable = 1'b0; sensors = 5'b11011;
    tick(2);
    check("rstState", 16'(state), S_IDLE);
    check("rstML", 16'(motor_left), 0);
    check("rstMR", 16'(motor_right), 0);
    check("rstLost", 16'(line_lost), 0);
    reset = 1'b0;
    tick(10);
    check("idleNoEn", 16'(state), S_IDLE);
    enable = 1'b1;
    tick(1);
    check("enFwd", 16'(state), S_FWD);
    tick(32);
    measure(hl, hr);
    check("fwdDutyL", 16'(hl), 12);
    check("fwdDutyR", 16'(hr), 12);

    // 2: left turn, 5-cycle latency, duty swaps only at the counter wrap
    sensors = 5'b11110;
    tick(4);
    check("latStillFwd", 16'(state), S_FWD);
    tick(1);
    check("latLeft", 16'(state), S_LEFT);
    mDuty = 12;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      cb = (cyc + 15) % 16;
      check("wrapLeft", 16'(motor_left), 16'(cb < mDuty));
      if (cb == 15) mDuty = 4;
    end
    measure(hl, hr);
    check("leftDutyL", 16'(hl), 4);
    check("leftDutyR", 16'(hr), 12);

    // 3: right, then lose the line: SEARCH towards last side R, then timeout STOP
    sensors = 5'b01111;
    tick(5);
    check("right", 16'(state), S_RIGHT);
    waitPhase(10);
    sensors = 5'b11111;
    tick(5);
    check("search", 16'(state), S_SEARCH);
    check("searchLost", 16'(line_lost), 1);
    tick(1);
    measure(hl, hr);
    check("searchDutyL", 16'(hl), 8);
    check("searchDutyR", 16'(hr), 0);
    tick(2);
    check("searchAt19", 16'(state), S_SEARCH);
    tick(1);
    check("timeoutStop", 16'(state), S_STOP);
    check("timeoutLost", 16'(line_lost), 1);
    tick(1);
    check("stopML", 16'(motor_left), 0);
    check("stopMR", 16'(motor_right), 0);
    check("stopLostHeld", 16'(line_lost), 1);

    // 4: reacquire inside the timeout, then a fresh full-length search
    enable = 1'b0;
    tick(1);
    check("disIdle", 16'(state), S_IDLE);
    check("disLost", 16'(line_lost), 0);
    sensors = 5'b11011;
    tick(6);
    enable = 1'b1;
    tick(1);
    check("reFwd", 16'(state), S_FWD);
    sensors = 5'b11111;
    tick(5);
    check("search2", 16'(state), S_SEARCH);
    tick(5);
    sensors = 5'b11011;
    tick(4);
    check("reacqPending", 16'(state), S_SEARCH);
    tick(1);
    check("reacqFwd", 16'(state), S_FWD);
    check("reacqLost", 16'(line_lost), 0);
    sensors = 5'b11111;
    tick(5);
    check("search3", 16'(state), S_SEARCH);
    tick(19);
    check("search3At19", 16'(state), S_SEARCH);
    tick(1);
    check("search3Stop", 16'(state), S_STOP);

    // 5: stop bar from FWD, enable cycling
    enable = 1'b0;
    sensors = 5'b11011;
    tick(6);
    check("idle5", 16'(state), S_IDLE);
    enable = 1'b1;
    tick(1);
    check("fwd5", 16'(state), S_FWD);
    sensors = 5'b00000;
    tick(5);
    check("stopBar", 16'(state), S_STOP);
    check("stopBarLost", 16'(line_lost), 0);
    tick(1);
    check("stopBarML", 16'(motor_left), 0);
    sensors = 5'b11111;
    tick(6);
    check("stopIgnores", 16'(state), S_STOP);
    enable = 1'b0;
    tick(1);
    check("idleAgain", 16'(state), S_IDLE);
    sensors = 5'b11011;
    tick(6);
    enable = 1'b1;
    tick(1);
    check("fwdAgain", 16'(state), S_FWD);

    // 6: one-cycle glitch is filtered; async reset drops motors at once
    tick(20);
    sensors = 5'b11110;
    tick(1);
    sensors = 5'b11011;
    tick(4);
    check("glitchA", 16'(state), S_FWD);
    tick(6);
    check("glitchB", 16'(state), S_FWD);
    for (int i = 0; i < 32 && motor_left !== 1'b1; i++) tick(1);
    check("preRstHigh", 16'(motor_left), 1);
    #2;
    reset = 1'b1;
    enable = 1'b0;
    sensors = 5'b11111;
    #1;
    check("asyncML", 16'(motor_left), 0);
    check("asyncMR", 16'(motor_right), 0);
    check("asyncState", 16'(state), S_IDLE);
    tick(2);
    reset = 1'b0;

    // 7: last side resets to L, so an immediate search spins on the right wheel
    waitPhase(13);
    enable = 1'b1;
    tick(2);
    check("rstSearch", 16'(state), S_SEARCH);
    check("rstSearchLost", 16'(line_lost), 1);
    tick(1);
    measure(hl, hr);
    check("rstSearchL", 16'(hl), 0);
    check("rstSearchR", 16'(hr), 8);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
